tl_inflight_checker: RTL

TL_INFLIGHT_CHECKER -- requirements
Module: tl_inflight_checker

---
 rtl/tl_inflight_checker.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/tl_inflight_checker.sv
// TileLink A/D channel protocol checker: tracks in-flight sources, burst framing and stall stability.
// Optional watchdog on stalled responses is built in when TL_CHECKER_WATCHDOG_EN is defined.
module tl_inflight_checker #(
    parameter int SOURCE_BITS = 4,
    parameter int SIZE_BITS   = 3,
    parameter int BEAT_LOG2   = 3,
    parameter int ADDR_BITS   = 28,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       a_valid,
    input  logic                       a_ready,
    input  logic [2:0]                 a_opcode,
    input  logic [SIZE_BITS-1:0]       a_size,
    input  logic [SOURCE_BITS-1:0]     a_source,
    input  logic [ADDR_BITS-1:0]       a_address,
    input  logic [(1<<BEAT_LOG2)-1:0]  a_mask,
    input  logic                       d_valid,
    input  logic                       d_ready,
    input  logic [2:0]                 d_opcode,
    input  logic [SIZE_BITS-1:0]       d_size,
    input  logic [SOURCE_BITS-1:0]     d_source,
    input  logic                       err_clear,
    output logic [6:0]                 err_flags,
    output logic [2:0]                 err_first,
    output logic                       err_pulse,
    output logic [SOURCE_BITS:0]       inflight_count,
    output logic                       a_busy,
    output logic                       d_busy
);

    localparam int MW    = 1 << BEAT_LOG2;
    localparam int NSRC  = 1 << SOURCE_BITS;
    localparam int CNT_W = 1 << SIZE_BITS;
    localparam logic [SIZE_BITS-1:0] BEAT_SZ = SIZE_BITS'(BEAT_LOG2);

    // Beats in a transfer, minus one; only data-carrying opcodes can span several beats.
    function automatic logic [CNT_W-1:0] beats_m1(input logic burst_op, input logic [SIZE_BITS-1:0] size);
        logic [CNT_W-1:0] r;
        r = '0;
        if (burst_op && (size > BEAT_SZ))
            r = (CNT_W'(1) << (size - BEAT_SZ)) - CNT_W'(1);
        return r;
    endfunction

    function automatic logic misaligned(input logic [ADDR_BITS-1:0] addr, input logic [SIZE_BITS-1:0] size);
        logic [ADDR_BITS-1:0] m;
        m = (ADDR_BITS'(1) << size) - ADDR_BITS'(1);
        return |(addr & m);
    endfunction

    function automatic logic [SOURCE_BITS:0] popcount(input logic [NSRC-1:0] v);
        logic [SOURCE_BITS:0] c;
        c = '0;
        for (int i = 0; i < NSRC; i++)
            c = c + {{SOURCE_BITS{1'b0}}, v[i]};
        return c;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [6:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 6; i >= 0; i--)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    logic a_fire, d_fire;
    logic a_first, d_first, a_last, d_last;
    logic [CNT_W-1:0] a_cnt, d_cnt, a_len, d_len, a_len_now, d_len_now;
    logic [2:0]             a_opc_b, d_opc_b;
    logic [SIZE_BITS-1:0]   a_size_b, d_size_b;
    logic [SOURCE_BITS-1:0] a_src_b, d_src_b;

    assign a_fire    = a_valid & a_ready;
    assign d_fire    = d_valid & d_ready;
    assign a_first   = (a_cnt == '0);
    assign d_first   = (d_cnt == '0);
    assign a_len_now = beats_m1((a_opcode == 3'd0) || (a_opcode == 3'd1), a_size);
    assign d_len_now = beats_m1(d_opcode == 3'd1, d_size);
    assign a_last    = a_first ? (a_len_now == '0) : (a_cnt == a_len);
    assign d_last    = d_first ? (d_len_now == '0) : (d_cnt == d_len);
    assign a_busy    = (a_cnt != '0);
    assign d_busy    = (d_cnt != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_cnt <= '0;
            d_cnt <= '0;
        end else begin
            if (a_fire) a_cnt <= a_last ? '0 : a_cnt + CNT_W'(1);
            if (d_fire) d_cnt <= d_last ? '0 : d_cnt + CNT_W'(1);
        end
    end

    // First-beat attributes, held for the rest of the burst.
    always_ff @(posedge clock) begin
        if (a_fire && a_first) begin
            a_len    <= a_len_now;
            a_opc_b  <= a_opcode;
            a_size_b <= a_size;
            a_src_b  <= a_source;
        end
        if (d_fire && d_first) begin
            d_len    <= d_len_now;
            d_opc_b  <= d_opcode;
            d_size_b <= d_size;
            d_src_b  <= d_source;
        end
    end

    logic [NSRC-1:0] inflight, bm_clr, bm_set, bm_after_clr, bm_next;

    // A response retiring a source frees it before a same-cycle request may claim it again.
    always_comb begin
        bm_clr = '0;
        bm_set = '0;
        if (d_fire && d_last) bm_clr[d_source] = 1'b1;
        if (a_fire && a_first) bm_set[a_source] = 1'b1;
        bm_after_clr = inflight & ~bm_clr;
        bm_next      = bm_after_clr | bm_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight       <= '0;
            inflight_count <= '0;
        end else begin
            inflight       <= bm_next;
            inflight_count <= popcount(bm_next);
        end
    end

    logic                   a_stall_vld_p1;
    logic [2:0]             a_opcode_p1;
    logic [SIZE_BITS-1:0]   a_size_p1;
    logic [SOURCE_BITS-1:0] a_source_p1;
    logic [ADDR_BITS-1:0]   a_address_p1;
    logic [MW-1:0]          a_mask_p1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_stall_vld_p1 <= 1'b0;
            a_opcode_p1    <= '0;
            a_size_p1      <= '0;
            a_source_p1    <= '0;
            a_address_p1   <= '0;
            a_mask_p1      <= '0;
        end else begin
            a_stall_vld_p1 <= a_valid & ~a_ready;
            a_opcode_p1    <= a_opcode;
            a_size_p1      <= a_size;
            a_source_p1    <= a_source;
            a_address_p1   <= a_address;
            a_mask_p1      <= a_mask;
        end
    end

    logic a_changed, wdog_hit;
    logic [6:0] err_new;

    assign a_changed = (a_opcode != a_opcode_p1) || (a_size != a_size_p1) ||
                       (a_source != a_source_p1) || (a_address != a_address_p1) ||
                       (a_mask != a_mask_p1);

    always_comb begin
        err_new    = '0;
        err_new[0] = a_fire & a_first & bm_after_clr[a_source];
        err_new[1] = d_fire & d_first & ~inflight[d_source];
        err_new[2] = a_stall_vld_p1 & (~a_valid | a_changed);
        err_new[3] = (a_fire & ~a_first & ((a_opcode != a_opc_b) || (a_size != a_size_b) || (a_source != a_src_b))) |
                     (d_fire & ~d_first & ((d_opcode != d_opc_b) || (d_size != d_size_b) || (d_source != d_src_b)));
        err_new[4] = a_fire & (a_opcode == 3'd0) & (a_size >= BEAT_SZ) & (a_mask != {MW{1'b1}});
        err_new[5] = a_fire & a_first & misaligned(a_address, a_size);
        err_new[6] = wdog_hit;
    end

`ifdef TL_CHECKER_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_cnt;
    logic            wdog_inc;

    assign wdog_inc = (inflight_count != '0) && !d_fire;
    assign wdog_hit = wdog_inc && (wdog_cnt == WD_W'(WDOG_CYCLES - 1));

    // Counts cycles with outstanding requests and no response traffic; holds at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wdog_cnt <= '0;
        else if (err_clear || !wdog_inc)
            wdog_cnt <= '0;
        else if (wdog_cnt != WD_W'(WDOG_CYCLES))
            wdog_cnt <= wdog_cnt + WD_W'(1);
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // A clear wipes history but keeps anything detected in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_flags <= '0;
            err_first <= '0;
            err_pulse <= 1'b0;
        end else if (err_clear) begin
            err_flags <= err_new;
            err_first <= lowest_set(err_new);
            err_pulse <= |err_new;
        end else begin
            err_flags <= err_flags | err_new;
            err_pulse <= |(err_new & ~err_flags);
            if ((err_flags == '0) && (|err_new))
                err_first <= lowest_set(err_new);
        end
    end

endmodule
